relin_ntt_stream: RTL

Streaming, NTT-domain relinearization unit: the parametrised successor to the tiled relinearization datapath. It accepts LANES-wide tiles of (c0, c1, c2) and decomposes each c2 coefficient into base-2^DIGIT_WIDTH digits. It returns (d0, d1) = (c0 + Σ digit_j·rk0_j, c1 + Σ digit_j·rk1_j) mod MOD_VALUE for both key halves in one pass, with full valid/ready backpressure. It sits between the pointwise ciphertext multiplier and the inverse-NTT/output buffer; relin keys are read digit-by-digit from an external key register file.

---
 rtl/relin_ntt_stream_if.sv | 16 +
 rtl/relin_ntt_stream.sv | 88 ++++++++
 2 files changed

// File: rtl/relin_ntt_stream_if.sv
// relin_ntt_stream_if: tile handshake bundle (ciphertext in, relinearized tile out)
interface relin_ntt_stream_if #(
    parameter int LANES = 8,
    parameter int DATA_WIDTH = 64
);
    logic s_valid, s_ready, m_valid, m_ready, m_last;
    logic [LANES-1:0][DATA_WIDTH-1:0] c0_i, c1_i, c2_i, d0_o, d1_o;
    modport slave (
        input  s_valid, c0_i, c1_i, c2_i, m_ready,
        output s_ready, m_valid, d0_o, d1_o, m_last
    );
    modport master (
        output s_valid, c0_i, c1_i, c2_i, m_ready,
        input  s_ready, m_valid, d0_o, d1_o, m_last
    );
endinterface

// File: rtl/relin_ntt_stream.sv
// relin_ntt_stream: digit-serial NTT-domain relinearization, one c2 digit per lane per cycle
module relin_ntt_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES = 8,
    parameter int DIGIT_WIDTH = 8,
    parameter int DEGREE = 512,
    parameter int MOD_VALUE = 1048193,
    localparam int NUM_DIGITS = (DATA_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH,
    localparam int NUM_TILES = DEGREE / LANES,
    localparam int TW = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1,
    localparam int DGW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic clk,
    input  logic rst,
    relin_ntt_stream_if.slave bus,
    output logic [TW-1:0] key_tile_o,
    output logic [DGW-1:0] key_digit_o,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] key0_i,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] key1_i,
    output logic done_o
);
    localparam int MOD_WIDTH = $clog2(MOD_VALUE);
    localparam int PW = DIGIT_WIDTH + MOD_WIDTH;
    localparam logic [MOD_WIDTH:0] Q_S = (MOD_WIDTH + 1)'(MOD_VALUE);
    localparam logic [PW-1:0] Q_P = PW'(MOD_VALUE);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t state;
    logic [LANES-1:0][NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] c2r;
    logic [LANES-1:0][MOD_WIDTH-1:0] acc0, acc1, nxt0, nxt1;
    logic [DGW-1:0] digit;
    logic [TW-1:0] tile;
    logic accept, out_hs, last_digit, last_tile;
    assign bus.s_ready = state == IDLE || (state == OUT && bus.m_ready);
    assign accept = bus.s_valid && bus.s_ready;
    assign out_hs = state == OUT && bus.m_ready;
    assign last_digit = digit == DGW'(NUM_DIGITS - 1);
    assign last_tile = tile == TW'(NUM_TILES - 1);
    assign bus.m_valid = state == OUT;
    assign bus.m_last = state == OUT && last_tile;
    assign key_tile_o = tile;
    assign key_digit_o = digit;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PW-1:0] p0, p1;
        logic [MOD_WIDTH:0] s0, s1;
        logic unused_g;
        assign p0 = PW'(c2r[g][digit]) * PW'(key0_i[g][MOD_WIDTH-1:0]);
        assign p1 = PW'(c2r[g][digit]) * PW'(key1_i[g][MOD_WIDTH-1:0]);
        assign s0 = {1'b0, acc0[g]} + {1'b0, MOD_WIDTH'(p0 % Q_P)};
        assign s1 = {1'b0, acc1[g]} + {1'b0, MOD_WIDTH'(p1 % Q_P)};
        assign nxt0[g] = MOD_WIDTH'(s0 >= Q_S ? s0 - Q_S : s0);
        assign nxt1[g] = MOD_WIDTH'(s1 >= Q_S ? s1 - Q_S : s1);
        assign bus.d0_o[g] = DATA_WIDTH'(acc0[g]);
        assign bus.d1_o[g] = DATA_WIDTH'(acc1[g]);
        // inputs are reduced below q, so bits above MOD_WIDTH carry no information
        assign unused_g = ^{key0_i[g][DATA_WIDTH-1:MOD_WIDTH], key1_i[g][DATA_WIDTH-1:MOD_WIDTH],
                            bus.c0_i[g][DATA_WIDTH-1:MOD_WIDTH], bus.c1_i[g][DATA_WIDTH-1:MOD_WIDTH]};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            c2r <= '0;
            acc0 <= '0;
            acc1 <= '0;
            digit <= '0;
            tile <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= out_hs && last_tile;
            if (out_hs) tile <= last_tile ? '0 : tile + 1'b1;
            if (accept) begin
                state <= ACCUM;
                digit <= '0;
                for (int i = 0; i < LANES; i++) begin
                    c2r[i] <= (NUM_DIGITS * DIGIT_WIDTH)'(bus.c2_i[i]);
                    acc0[i] <= bus.c0_i[i][MOD_WIDTH-1:0];
                    acc1[i] <= bus.c1_i[i][MOD_WIDTH-1:0];
                end
            end else if (state == ACCUM) begin
                acc0 <= nxt0;
                acc1 <= nxt1;
                digit <= last_digit ? '0 : digit + 1'b1;
                state <= last_digit ? OUT : ACCUM;
            end else if (out_hs) begin
                state <= IDLE;
            end
        end
    end
endmodule
